input_conditioner: RTL and testbench

//  Multi-channel successor to the single-bit edge_detect/pulse_stretcher utilities.
//  Per channel: synchronise an async input, glitch-filter it, emit rising/falling strobes,

---
 rtl/input_conditioner_pkg.sv | 14 +
 rtl/input_conditioner_channel.sv | 99 +++++++++
 rtl/input_conditioner.sv | 49 ++++
 tb/tb_input_conditioner.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// rtl/input_conditioner_pkg.sv - shared defaults and counter-width helper for input_conditioner
package input_conditioner_pkg;

    localparam int DEF_CHANNELS       = 4;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_FILTER_CYCLES  = 4;
    localparam int DEF_STRETCH_CYCLES = 16;

    // Bits needed to count 0..value-1, never less than one bit
    function automatic int clog2(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// rtl/input_conditioner_channel.sv - one channel: sync, glitch filter, strobes, stretch, sticky event
module input_conditioner_channel
    import input_conditioner_pkg::*;
#(
    parameter int   SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int   FILTER_CYCLES  = DEF_FILTER_CYCLES,
    parameter int   STRETCH_CYCLES = DEF_STRETCH_CYCLES,
    parameter logic RESET_BIT      = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_in,
    input  logic i_rise_en,
    input  logic i_fall_en,
    input  logic i_event_clear,
    output logic o_level,
    output logic o_rising,
    output logic o_falling,
    output logic o_stretched,
    output logic o_event_pending
);

    localparam int FW = clog2(FILTER_CYCLES + 1);
    localparam int SW = clog2(STRETCH_CYCLES + 1);
    localparam logic [FW-1:0] FILTER_LAST  = FW'(FILTER_CYCLES - 1);
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FW-1:0]          r_fcnt;
    logic [SW-1:0]          r_scnt;
    logic                   r_level;
    logic                   r_rising;
    logic                   r_falling;
    logic                   r_pending;
    logic                   w_sample;

    assign w_sample = r_sync[SYNC_STAGES-1];

    // Shift the raw pin through the synchroniser chain
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync <= {SYNC_STAGES{RESET_BIT}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
        end
    end

    // Accept a new level only after FILTER_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_level   <= RESET_BIT;
            r_fcnt    <= '0;
            r_rising  <= 1'b0;
            r_falling <= 1'b0;
        end else begin
            r_rising  <= 1'b0;
            r_falling <= 1'b0;
            if (w_sample == r_level) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FILTER_LAST) begin
                r_level   <= w_sample;
                r_fcnt    <= '0;
                r_rising  <= w_sample;
                r_falling <= ~w_sample;
            end else begin
                r_fcnt <= r_fcnt + FW'(1);
            end
        end
    end

    // Reload the stretch counter on each rising strobe, otherwise count down to zero
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_scnt <= '0;
        end else if (r_rising) begin
            r_scnt <= STRETCH_LOAD;
        end else if (r_scnt != '0) begin
            r_scnt <= r_scnt - SW'(1);
        end
    end

    // Sticky event flag; a new enabled strobe overrides a simultaneous clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~i_event_clear)
                       | (r_rising & i_rise_en)
                       | (r_falling & i_fall_en);
        end
    end

    assign o_level         = r_level;
    assign o_rising        = r_rising;
    assign o_falling       = r_falling;
    assign o_stretched     = r_level | (r_scnt != '0);
    assign o_event_pending = r_pending;

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - multi-channel input conditioner with interrupt reduction
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int                   CHANNELS       = DEF_CHANNELS,
    parameter int                   SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int                   FILTER_CYCLES  = DEF_FILTER_CYCLES,
    parameter int                   STRETCH_CYCLES = DEF_STRETCH_CYCLES,
    parameter logic [CHANNELS-1:0]  RESET_LEVEL    = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] in,
    input  logic [CHANNELS-1:0] rise_en,
    input  logic [CHANNELS-1:0] fall_en,
    input  logic [CHANNELS-1:0] event_clear,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rising,
    output logic [CHANNELS-1:0] falling,
    output logic [CHANNELS-1:0] stretched,
    output logic [CHANNELS-1:0] event_pending,
    output logic                irq
);

    // Channels are fully independent copies
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        input_conditioner_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .FILTER_CYCLES  (FILTER_CYCLES),
            .STRETCH_CYCLES (STRETCH_CYCLES),
            .RESET_BIT      (RESET_LEVEL[g])
        ) u_ch (
            .clk             (clk),
            .reset_n         (reset_n),
            .i_in            (in[g]),
            .i_rise_en       (rise_en[g]),
            .i_fall_en       (fall_en[g]),
            .i_event_clear   (event_clear[g]),
            .o_level         (level[g]),
            .o_rising        (rising[g]),
            .o_falling       (falling[g]),
            .o_stretched     (stretched[g]),
            .o_event_pending (event_pending[g])
        );
    end

    assign irq = |event_pending;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - randomized scoreboard bench for input_conditioner
module tb_input_conditioner;

    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int STR  = 16;
    localparam logic [CH-1:0] RL = '0;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [CH-1:0] t_in = '0, t_rise_en = '0, t_fall_en = '0, t_clear = '0;
    logic [CH-1:0] level, rising, falling, stretched, event_pending;
    logic          irq;

    int errors = 0;
    int checks = 0;

    input_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT),
        .STRETCH_CYCLES(STR), .RESET_LEVEL(RL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in(t_in), .rise_en(t_rise_en),
        .fall_en(t_fall_en), .event_clear(t_clear), .level(level),
        .rising(rising), .falling(falling), .stretched(stretched),
        .event_pending(event_pending), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    typedef struct packed {
        logic [CH-1:0] lvl;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic [CH-1:0] str;
        logic [CH-1:0] pend;
        logic          irq;
    } exp_t;

    exp_t          exp_q[$];
    logic [CH-1:0] hist[$];
    logic [CH-1:0] m_level = RL, m_rise = '0, m_fall = '0, m_pend = '0, m_new, m_str;
    int            m_last_rise[CH];
    int            edge_no = 0;
    bit            all_diff;

    // Reference model: a level is accepted when the last FILT synchronised samples all
    // disagree with it; stretched is high while fewer than STR cycles have passed since a rise.
    initial begin
        forever begin
            @(posedge clk);
            edge_no++;
            if (!reset_n) begin
                m_level = RL; m_rise = '0; m_fall = '0; m_pend = '0;
                for (int c = 0; c < CH; c++) m_last_rise[c] = -100000;
                hist.delete();
                for (int k = 0; k < 8; k++) hist.push_back(RL);
            end else begin
                m_pend = (m_pend & ~t_clear) | (m_rise & t_rise_en) | (m_fall & t_fall_en);
                for (int c = 0; c < CH; c++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < FILT; j++)
                        if (hist[hist.size() - SYNC - j][c] == m_level[c]) all_diff = 1'b0;
                    m_new[c] = all_diff ? ~m_level[c] : m_level[c];
                end
                m_rise  = m_new & ~m_level;
                m_fall  = ~m_new & m_level;
                m_level = m_new;
                for (int c = 0; c < CH; c++) if (m_rise[c]) m_last_rise[c] = edge_no;
                hist.push_back(t_in);
                if (hist.size() > 32) void'(hist.pop_front());
            end
            for (int c = 0; c < CH; c++)
                m_str[c] = m_level[c] | ((edge_no - m_last_rise[c]) < STR);
            exp_q.push_back('{m_level, m_rise, m_fall, m_str, m_pend, |m_pend});
        end
    end

    // Monitor: compare every presented cycle against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("level",         32'(level),         32'(e.lvl));
                check("rising",        32'(rising),        32'(e.rise));
                check("falling",       32'(falling),       32'(e.fall));
                check("stretched",     32'(stretched),     32'(e.str));
                check("event_pending", 32'(event_pending), 32'(e.pend));
                check("irq",           32'(irq),           32'(e.irq));
                check("rise_and_fall", 32'(rising & falling), 32'(0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) tick();
    endtask

    int cnt;

    initial begin
        // Reset held with active inputs: every output stays low
        reset_n = 1'b0; t_in = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("reset_hold_out", 32'({level, rising, falling, stretched, event_pending, irq}), 32'(0));
        end
        reset_n = 1'b1;
        tick();
        check("reset_release_out", 32'({level, rising, falling, stretched, event_pending, irq}), 32'(0));
        t_in = '0;
        wait_edges(10);

        // Clean step on ch0: accepted at edge SYNC+FILT, strobe one cycle, event one cycle later
        t_rise_en = 4'b0001; t_fall_en = '0;
        t_in[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("step_rising0", 32'(rising[0]), 32'(k == SYNC + FILT));
            check("step_level0",  32'(level[0]),  32'(k >= SYNC + FILT));
            if (k == SYNC + FILT + 1) begin
                check("step_pending0", 32'(event_pending[0]), 32'(1));
                check("step_irq",      32'(irq),              32'(1));
            end
        end

        // Glitch on ch1: 3 samples rejected, 4 samples accepted
        for (int w = 3; w <= 4; w++) begin
            cnt = 0;
            t_in[1] = 1'b1;
            for (int k = 1; k <= 14; k++) begin
                tick();
                if (k == w) t_in[1] = 1'b0;
                if (rising[1]) cnt++;
            end
            check(w == 3 ? "glitch3_rises" : "glitch4_rises", 32'(cnt), 32'(w == 4));
        end

        // Rise on ch3 with its event disabled: nothing latched
        t_in[3] = 1'b1;
        wait_edges(10);
        check("masked_pending3", 32'(event_pending[3]), 32'(0));

        // Stretch on ch2: minimum-width pulse stretched to STR, long pulse follows level
        cnt = 0;
        t_in[2] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == FILT) t_in[2] = 1'b0;
            if (stretched[2]) cnt++;
        end
        check("stretch_short", 32'(cnt), 32'(STR));
        cnt = 0;
        t_in[2] = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (k == 40) t_in[2] = 1'b0;
            if (stretched[2]) cnt++;
        end
        check("stretch_long", 32'(cnt), 32'(40));

        // Reset while ch0 filter is part-way: no strobe afterwards, level back to reset value
        t_in[0] = 1'b0;
        wait_edges(10);
        t_in[0] = 1'b1;
        wait_edges(4);
        reset_n = 1'b0; t_in = '0;
        tick();
        reset_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (rising[0]) cnt++;
        end
        check("midfilter_rises0", 32'(cnt), 32'(0));
        check("midfilter_level0", 32'(level[0]), 32'(RL[0]));

        // Randomized traffic: long and short runs, mask/clear churn, rare resets
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(5) == 0) t_in[c] = ~t_in[c];
            if ($urandom_range(15) == 0) t_rise_en = 4'($urandom);
            if ($urandom_range(15) == 0) t_fall_en = 4'($urandom);
            t_clear = ($urandom_range(3) == 0) ? 4'($urandom) : '0;
            reset_n = ($urandom_range(400) != 0);
            tick();
        end
        reset_n = 1'b1;
        wait_edges(3);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
